// File: rtl/startup_seq_ctrl.sv
// Post-configuration startup sequencer for STARTUP_VIRTEX6: releases GSR, then GTS,
// drives DONE, bursts user CCLK, and re-asserts the globals on EOS loss or abort.
module startup_seq_ctrl #(
    parameter int GSR_HOLD_CYCLES  = 16,
    parameter int GTS_HOLD_CYCLES  = 8,
    parameter int DONE_HOLD_CYCLES = 4,
    parameter int CCLK_DIV         = 4,
    parameter int CCLK_PULSES      = 8,
    parameter int CNT_W            = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic START,
    input  logic ABORT,
    input  logic EOS,
    output logic GSR_O,
    output logic GTS_O,
    output logic USRDONEO,
    output logic USRDONETS,
    output logic USRCCLKO,
    output logic USRCCLKTS,
    output logic BUSY,
    output logic READY,
    output logic ERR
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_EOS,
        ST_HOLD_GSR,
        ST_HOLD_GTS,
        ST_DONE_DRV,
        ST_CCLK_BURST,
        ST_RUN
    } state_t;

    // Zero-length phases are stretched to one cycle so every phase is observable.
    localparam logic [CNT_W-1:0] GSR_LOAD  = (GSR_HOLD_CYCLES  < 1) ? CNT_W'(1) : CNT_W'(GSR_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] GTS_LOAD  = (GTS_HOLD_CYCLES  < 1) ? CNT_W'(1) : CNT_W'(GTS_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] DONE_LOAD = (DONE_HOLD_CYCLES < 1) ? CNT_W'(1) : CNT_W'(DONE_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = (CCLK_DIV         < 1) ? CNT_W'(1) : CNT_W'(CCLK_DIV);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(2 * CCLK_PULSES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               SKIP_BURST = (CCLK_PULSES == 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             eos_meta_q, eos_meta_d;
    logic             eos_s_q, eos_s_d;
    logic             gsr_q, gsr_d;
    logic             gts_q, gts_d;
    logic             done_o_q, done_o_d;
    logic             done_ts_q, done_ts_d;
    logic             cclk_q, cclk_d;
    logic             cclk_ts_q, cclk_ts_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             eos_lost;

    always_comb begin
        eos_lost = !eos_s_q && (state_q != ST_IDLE) && (state_q != ST_WAIT_EOS);
    end

    always_comb begin
        eos_meta_d = EOS;
        eos_s_d    = eos_meta_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        gsr_d      = gsr_q;
        gts_d      = gts_q;
        done_o_d   = done_o_q;
        done_ts_d  = done_ts_q;
        cclk_d     = cclk_q;
        cclk_ts_d  = cclk_ts_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        err_d      = err_q;

        if (ABORT) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            half_d    = '0;
            gsr_d     = 1'b1;
            gts_d     = 1'b1;
            done_o_d  = 1'b0;
            done_ts_d = 1'b1;
            cclk_d    = 1'b0;
            cclk_ts_d = 1'b1;
            busy_d    = 1'b0;
            ready_d   = 1'b0;
        end else if (eos_lost) begin
            // Device lost configuration: put the globals back and wait for EOS again.
            state_d   = ST_WAIT_EOS;
            cnt_d     = '0;
            half_d    = '0;
            gsr_d     = 1'b1;
            gts_d     = 1'b1;
            done_o_d  = 1'b0;
            done_ts_d = 1'b1;
            cclk_d    = 1'b0;
            cclk_ts_d = 1'b1;
            busy_d    = 1'b1;
            ready_d   = 1'b0;
            err_d     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        state_d = ST_WAIT_EOS;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                    end
                end
                ST_WAIT_EOS: begin
                    if (eos_s_q) begin
                        state_d = ST_HOLD_GSR;
                        cnt_d   = GSR_LOAD;
                    end
                end
                ST_HOLD_GSR: begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_HOLD_GTS;
                        gsr_d   = 1'b0;
                        cnt_d   = GTS_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_HOLD_GTS: begin
                    if (cnt_q == CNT_ONE) begin
                        state_d   = ST_DONE_DRV;
                        gts_d     = 1'b0;
                        done_o_d  = 1'b1;
                        done_ts_d = 1'b0;
                        cnt_d     = DONE_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_DONE_DRV: begin
                    if (cnt_q == CNT_ONE) begin
                        if (SKIP_BURST) begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                            busy_d  = 1'b0;
                            ready_d = 1'b1;
                        end else begin
                            state_d   = ST_CCLK_BURST;
                            cclk_ts_d = 1'b0;
                            cclk_d    = 1'b1;
                            cnt_d     = DIV_LOAD;
                            half_d    = HALF_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_CCLK_BURST: begin
                    // cnt_q times one half-period; half_q counts half-periods left in the burst.
                    if (cnt_q == CNT_ONE) begin
                        if (half_q == CNT_ONE) begin
                            state_d   = ST_RUN;
                            cnt_d     = '0;
                            half_d    = '0;
                            cclk_d    = 1'b0;
                            cclk_ts_d = 1'b1;
                            busy_d    = 1'b0;
                            ready_d   = 1'b1;
                        end else begin
                            cclk_d = !cclk_q;
                            cnt_d  = DIV_LOAD;
                            half_d = half_q - CNT_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            half_q     <= '0;
            eos_meta_q <= 1'b0;
            eos_s_q    <= 1'b0;
            gsr_q      <= 1'b1;
            gts_q      <= 1'b1;
            done_o_q   <= 1'b0;
            done_ts_q  <= 1'b1;
            cclk_q     <= 1'b0;
            cclk_ts_q  <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            eos_meta_q <= eos_meta_d;
            eos_s_q    <= eos_s_d;
            gsr_q      <= gsr_d;
            gts_q      <= gts_d;
            done_o_q   <= done_o_d;
            done_ts_q  <= done_ts_d;
            cclk_q     <= cclk_d;
            cclk_ts_q  <= cclk_ts_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    assign GSR_O     = gsr_q;
    assign GTS_O     = gts_q;
    assign USRDONEO  = done_o_q;
    assign USRDONETS = done_ts_q;
    assign USRCCLKO  = cclk_q;
    assign USRCCLKTS = cclk_ts_q;
    assign BUSY      = busy_q;
    assign READY     = ready_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_startup_seq_ctrl.sv
// Directed bench for startup_seq_ctrl: expectations are queued per cycle as stimulus is
// driven and compared at the falling edge; a second instance covers the no-burst build.
module tb_startup_seq_ctrl;

    // Output vector bit order: GSR GTS DONEO DONETS CCLKO CCLKTS BUSY READY ERR
    localparam logic [8:0] RST_V    = 9'b110101000;
    localparam logic [8:0] WAIT_V   = 9'b110101100;
    localparam logic [8:0] GTSH_V   = 9'b010101100;
    localparam logic [8:0] DONE_V   = 9'b001001100;
    localparam logic [8:0] BHI_V    = 9'b001010100;
    localparam logic [8:0] BLO_V    = 9'b001000100;
    localparam logic [8:0] RUN_V    = 9'b001001010;
    localparam logic [8:0] LOST_V   = 9'b110101101;
    localparam logic [8:0] M_ALL    = 9'h1FF;
    localparam logic [8:0] M_GSR    = 9'b100000000;
    localparam logic [8:0] M_GTS    = 9'b010000000;
    localparam logic [8:0] M_CCLK   = 9'b000010000;
    localparam logic [8:0] M_CCLKTS = 9'b000001000;

    typedef struct {
        string      tag;
        int         at;
        bit         inst;
        logic [8:0] exp;
        logic [8:0] mask;
    } exp_t;

    logic clk;
    logic rst, start, abort, eos;
    logic gsr_a, gts_a, dono_a, dots_a, cko_a, ckts_a, busy_a, ready_a, err_a;
    logic gsr_b, gts_b, dono_b, dots_b, cko_b, ckts_b, busy_b, ready_b, err_b;
    logic [8:0] out_a, out_b;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   e;
    exp_t sb[$];
    exp_t cur;

    startup_seq_ctrl u_dut_a (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .EOS(eos),
        .GSR_O(gsr_a), .GTS_O(gts_a), .USRDONEO(dono_a), .USRDONETS(dots_a),
        .USRCCLKO(cko_a), .USRCCLKTS(ckts_a), .BUSY(busy_a), .READY(ready_a), .ERR(err_a)
    );

    startup_seq_ctrl #(
        .GSR_HOLD_CYCLES(0), .GTS_HOLD_CYCLES(8), .DONE_HOLD_CYCLES(4),
        .CCLK_DIV(4), .CCLK_PULSES(0), .CNT_W(16)
    ) u_dut_b (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .EOS(eos),
        .GSR_O(gsr_b), .GTS_O(gts_b), .USRDONEO(dono_b), .USRDONETS(dots_b),
        .USRCCLKO(cko_b), .USRCCLKTS(ckts_b), .BUSY(busy_b), .READY(ready_b), .ERR(err_b)
    );

    assign out_a = {gsr_a, gts_a, dono_a, dots_a, cko_a, ckts_a, busy_a, ready_a, err_a};
    assign out_b = {gsr_b, gts_b, dono_b, dots_b, cko_b, ckts_b, busy_b, ready_b, err_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: cycle=%0d pending=%0d expected 0 pending", cyc, sb.size());
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic r, input logic s, input logic a, input logic ev);
        rst   = r;
        start = s;
        abort = a;
        eos   = ev;
    endtask

    task automatic expectAt(input string tag, input int at, input bit inst,
                            input logic [8:0] exp, input logic [8:0] mask);
        exp_t item;
        int   idx;
        item.tag  = tag;
        item.at   = at;
        item.inst = inst;
        item.exp  = exp;
        item.mask = mask;
        idx = sb.size();
        while (idx > 0 && sb[idx-1].at > at) idx--;
        sb.insert(idx, item);
    endtask

    task automatic checkOutput(input exp_t ex, input logic [8:0] obs);
        checks++;
        assert ((obs & ex.mask) === (ex.exp & ex.mask)) else begin
            errors++;
            $error("[TB] FAIL %s (inst %0d) cycle %0d: observed %b expected %b mask %b",
                   ex.tag, ex.inst, cyc, obs, ex.exp, ex.mask);
        end
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Scoreboard drain: every expectation due at this cycle is compared now.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            cur = sb.pop_front();
            if (cur.at != cyc) begin
                checks++;
                errors++;
                $error("[TB] FAIL %s stale: due cycle %0d observed at cycle %0d", cur.tag, cur.at, cyc);
            end else begin
                checkOutput(cur, cur.inst ? out_b : out_a);
            end
        end
    end

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        expectAt("reset_a", 3, 1'b0, RST_V, M_ALL);
        expectAt("reset_b", 3, 1'b1, RST_V, M_ALL);

        // Default sequence with EOS rising after START.
        waitUntil(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        expectAt("start_busy_a", 4, 1'b0, WAIT_V, M_ALL);
        expectAt("start_busy_b", 4, 1'b1, WAIT_V, M_ALL);
        waitUntil(4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        e = 5;
        expectAt("wait_eos", e + 1, 1'b0, WAIT_V, M_ALL);
        expectAt("gsr_held", e + 17, 1'b0, WAIT_V, M_GSR);
        expectAt("gsr_fall", e + 18, 1'b0, GTSH_V, M_ALL);
        expectAt("gts_held", e + 25, 1'b0, GTSH_V, M_GTS);
        expectAt("gts_fall_done", e + 26, 1'b0, DONE_V, M_ALL);
        expectAt("done_hold", e + 29, 1'b0, DONE_V, M_ALL);
        expectAt("burst_entry", e + 30, 1'b0, BHI_V, M_ALL);
        for (int i = 0; i < 8; i++) begin
            expectAt("cclk_hi_first", e + 30 + 8 * i, 1'b0, BHI_V, M_CCLK);
            expectAt("cclk_hi_last", e + 33 + 8 * i, 1'b0, BHI_V, M_CCLK);
            expectAt("cclk_lo_first", e + 34 + 8 * i, 1'b0, BLO_V, M_CCLK);
        end
        expectAt("burst_tail", e + 93, 1'b0, BLO_V, M_ALL);
        expectAt("ready", e + 94, 1'b0, RUN_V, M_ALL);
        expectAt("run_stable", e + 100, 1'b0, RUN_V, M_ALL);
        expectAt("b_gsr_held", e + 2, 1'b1, WAIT_V, M_ALL);
        expectAt("b_gsr_fall", e + 3, 1'b1, GTSH_V, M_ALL);
        expectAt("b_done", e + 11, 1'b1, DONE_V, M_ALL);
        expectAt("b_done_hold", e + 14, 1'b1, DONE_V, M_ALL);
        expectAt("b_ready", e + 15, 1'b1, RUN_V, M_ALL);
        for (int t = e + 1; t <= e + 40; t++) begin
            expectAt("b_cclkts_released", t, 1'b1, RST_V, M_CCLKTS);
        end

        // ABORT from RUN, then START with ABORT held.
        waitUntil(105);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        expectAt("abort_run_a", 106, 1'b0, RST_V, M_ALL);
        expectAt("abort_run_b", 106, 1'b1, RST_V, M_ALL);
        waitUntil(106);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        expectAt("start_abort_idle", 107, 1'b0, RST_V, M_ALL);
        waitUntil(107);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // START with EOS already synchronized; then drop EOS mid-burst.
        waitUntil(108);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        expectAt("pre_eos_wait", 109, 1'b0, WAIT_V, M_ALL);
        expectAt("pre_eos_hold", 110, 1'b0, WAIT_V, M_ALL);
        expectAt("pre_eos_gsr_held", 125, 1'b0, WAIT_V, M_ALL);
        expectAt("pre_eos_gsr_fall", 126, 1'b0, GTSH_V, M_ALL);
        expectAt("b_pre_eos_gsr_fall", 111, 1'b1, GTSH_V, M_ALL);
        waitUntil(109);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        waitUntil(140);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expectAt("loss_burst_hi", 141, 1'b0, BHI_V, M_ALL);
        expectAt("loss_burst_lo", 142, 1'b0, BLO_V, M_ALL);
        expectAt("eos_loss", 143, 1'b0, LOST_V, M_ALL);
        expectAt("b_loss_run", 142, 1'b1, RUN_V, M_ALL);
        expectAt("b_eos_loss", 143, 1'b1, LOST_V, M_ALL);
        waitUntil(145);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        e = 146;
        expectAt("loss_wait", e, 1'b0, LOST_V, M_ALL);
        expectAt("rerun_wait", e + 1, 1'b0, LOST_V, M_ALL);
        expectAt("rerun_gsr_held", e + 17, 1'b0, LOST_V, M_ALL);
        expectAt("rerun_gsr_fall", e + 18, 1'b0, GTSH_V | 9'b1, M_ALL);
        expectAt("rerun_done", e + 26, 1'b0, DONE_V | 9'b1, M_ALL);
        expectAt("rerun_burst", e + 30, 1'b0, BHI_V | 9'b1, M_ALL);
        expectAt("rerun_ready_err", e + 94, 1'b0, RUN_V | 9'b1, M_ALL);

        // ABORT keeps ERR; START clears it; then ABORT in HOLD_GTS.
        waitUntil(242);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        expectAt("abort_keeps_err", 243, 1'b0, RST_V | 9'b1, M_ALL);
        waitUntil(243);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        expectAt("start_clears_err", 244, 1'b0, WAIT_V, M_ALL);
        waitUntil(244);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectAt("hold_gsr_again", 260, 1'b0, WAIT_V, M_ALL);
        expectAt("gsr_fall_again", 261, 1'b0, GTSH_V, M_ALL);
        expectAt("in_hold_gts", 264, 1'b0, GTSH_V, M_ALL);
        waitUntil(264);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        expectAt("abort_gts_a", 265, 1'b0, RST_V, M_ALL);
        expectAt("abort_gts_b", 265, 1'b1, RST_V, M_ALL);
        waitUntil(265);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        expectAt("start_abort_idle2", 266, 1'b0, RST_V, M_ALL);
        waitUntil(266);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // RST mid-HOLD_GSR (START ignored under reset), then RST mid-RUN.
        waitUntil(267);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        expectAt("start_again", 268, 1'b0, WAIT_V, M_ALL);
        waitUntil(268);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        waitUntil(275);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        expectAt("rst_hold_gsr_a", 276, 1'b0, RST_V, M_ALL);
        expectAt("rst_hold_gsr_b", 276, 1'b1, RST_V, M_ALL);
        waitUntil(276);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        expectAt("rst_start_ignored", 277, 1'b0, RST_V, M_ALL);
        waitUntil(277);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectAt("post_rst_idle_a", 278, 1'b0, RST_V, M_ALL);
        expectAt("post_rst_idle_b", 278, 1'b1, RST_V, M_ALL);
        waitUntil(278);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        expectAt("start_after_rst", 279, 1'b0, WAIT_V, M_ALL);
        waitUntil(279);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectAt("post_rst_gsr_held", 295, 1'b0, WAIT_V, M_ALL);
        expectAt("post_rst_gsr_fall", 296, 1'b0, GTSH_V, M_ALL);
        expectAt("post_rst_ready", 372, 1'b0, RUN_V, M_ALL);
        expectAt("post_rst_run", 379, 1'b0, RUN_V, M_ALL);
        expectAt("b_post_rst_gsr_fall", 281, 1'b1, GTSH_V, M_ALL);
        expectAt("b_post_rst_ready", 293, 1'b1, RUN_V, M_ALL);
        waitUntil(380);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        expectAt("rst_run_a", 381, 1'b0, RST_V, M_ALL);
        expectAt("rst_run_b", 381, 1'b1, RST_V, M_ALL);
        waitUntil(381);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        waitUntil(384);

        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/startup_seq_ctrl.md
Name: startup_seq_ctrl

Overview:
- Post-configuration startup sequencer. It sits between user logic and the STARTUP_VIRTEX6 primitive.
- After configuration reports end-of-startup (EOS), it releases global set/reset (GSR), then global tristate (GTS). It then drives DONE and issues a burst of user CCLK pulses on USRCCLKO.
- It reports READY once the device is fully released. It handles EOS loss and user abort by re-asserting the globals.

Parameters:
GSR_HOLD_CYCLES, 16, cycles GSR_O stays high after EOS is seen (0 treated as 1)
GTS_HOLD_CYCLES, 8, cycles from GSR_O release to GTS_O release (0 treated as 1)
DONE_HOLD_CYCLES, 4, cycles DONE is driven before the CCLK burst (0 treated as 1)
CCLK_DIV, 4, CLK cycles per USRCCLKO half-period (>=1)
CCLK_PULSES, 8, number of USRCCLKO high/low pulses in the burst (0 = skip burst)
CNT_W, 16, width of the shared phase counter; must hold max(all of the above)

Ports:
CLK  input  1  system clock
RST  input  1  synchronous active-high reset
START  input  1  begin sequence; honoured only in IDLE
ABORT  input  1  return to IDLE and re-assert globals
EOS  input  1  end-of-startup from primitive; asynchronous to CLK
GSR_O  output  1  to primitive GSR
GTS_O  output  1  to primitive GTS
USRDONEO  output  1  DONE value
USRDONETS  output  1  DONE tristate (1 = released)
USRCCLKO  output  1  user CCLK
USRCCLKTS  output  1  CCLK tristate (1 = released)
BUSY  output  1  sequence in progress
READY  output  1  sequence complete, device running
ERR  output  1  sticky: EOS dropped mid-sequence

Behaviour:
- Interface decided: one clock CLK; RST is synchronous, active-high. All outputs are registered.
- Reset values, applied at the first CLK edge with RST=1:
  - state=IDLE
  - GSR_O=1, GTS_O=1
  - USRDONEO=0, USRDONETS=1
  - USRCCLKO=0, USRCCLKTS=1
  - BUSY=0, READY=0, ERR=0
  - counter=0, EOS synchronizer=0
- EOS passes through a 2-flop synchronizer (eos_s). The FSM uses only eos_s.
- States and transitions:
  - IDLE: globals asserted. START=1 -> WAIT_EOS next cycle; BUSY=1; ERR cleared.
  - WAIT_EOS: eos_s=1 -> HOLD_GSR, counter loaded.
  - HOLD_GSR: lasts exactly GSR_HOLD_CYCLES cycles. On exit GSR_O=0 -> HOLD_GTS.
  - HOLD_GTS: lasts GTS_HOLD_CYCLES cycles. On exit GTS_O=0 -> DONE_DRV.
  - DONE_DRV: on entry USRDONETS=0, USRDONEO=1. Lasts DONE_HOLD_CYCLES cycles. Exit goes to CCLK_BURST, or to RUN if CCLK_PULSES=0.
  - CCLK_BURST: on entry USRCCLKTS=0. USRCCLKO toggles every CCLK_DIV cycles, starting high on entry. The burst ends after CCLK_PULSES complete high+low pulses (2*CCLK_DIV*CCLK_PULSES cycles). Then USRCCLKO=0, USRCCLKTS=1 -> RUN.
  - RUN: READY=1, BUSY=0. DONE stays driven (USRDONETS=0, USRDONEO=1). GSR_O and GTS_O stay 0. Exits only on ABORT, RST, or EOS loss.
- EOS loss: eos_s=0 in any state HOLD_GSR through RUN:
  - next cycle GSR_O=1, GTS_O=1, USRDONETS=1, USRDONEO=0, USRCCLKO=0, USRCCLKTS=1
  - ERR=1, READY=0, BUSY=1
  - state=WAIT_EOS; the sequence restarts when EOS returns.
- ABORT=1 in any state: next cycle all outputs take reset values except ERR, which is held; state=IDLE.
- Priority: RST > ABORT > EOS loss > normal transition. START and ABORT together in IDLE: stay in IDLE.
- START outside IDLE is ignored.
- The counter is a single down-counter, reloaded on each phase entry. There is no wrap; a phase exits when the count reaches 1.
- Timing reference: let e be the first edge at which the synchronizer captures EOS=1.
  - HOLD_GSR is entered at e+2.
  - GSR_O falls at e+2+GSR_HOLD_CYCLES.
  - GTS_O falls GTS_HOLD_CYCLES later.

Test Plan:
- Defaults; RST 3 cycles; START pulse; EOS high stable from edge e:
  - GSR_O falls at e+18
  - GTS_O falls at e+26
  - USRDONETS=0 at e+26
  - first USRCCLKO rise at e+30
  - 8 pulses of 8-cycle period
  - READY=1 at e+94; BUSY=0 there.
- EOS already high before START:
  - WAIT_EOS lasts 1 cycle (sync already full)
  - GSR_O falls 16 cycles after HOLD_GSR entry.
- EOS drops during CCLK_BURST:
  - 3 cycles later (2 sync + 1) GSR_O=1, GTS_O=1, USRCCLKO=0, USRCCLKTS=1, ERR=1
  - re-raise EOS -> full sequence repeats; ERR stays 1 until the next START in IDLE.
- ABORT in RUN and ABORT in HOLD_GTS:
  - next cycle all outputs at reset values, state IDLE
  - START with ABORT held -> remains IDLE.
- CCLK_PULSES=0, GSR_HOLD_CYCLES=0:
  - GSR_O falls 1 cycle after HOLD_GSR entry
  - USRCCLKTS never drops
  - READY 4 cycles after USRDONETS=0.
- RST asserted mid-HOLD_GSR and mid-RUN:
  - all outputs at reset values after the edge
  - START ignored while RST=1.
